// File: rtl/mc_ctrl_fsm_hs_pkg.sv
// Shared definitions for the handshaked multicycle control FSM.
//   state_t  : state encoding (also exported on state_o for debug)
//   SRC*/RES*: datapath mux-select constants
//   ctrl_t   : 13-bit control bundle, field order
//              {NextPC, Branch, MemW, RegW, IRWrite, AdrSrc,
//               ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ALUOp}
package mc_ctrl_fsm_hs_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_FAULT    = 4'd10
    } state_t;

    localparam logic [1:0] SRCA_RN    = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCB_RM    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_4     = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    typedef struct packed {
        logic       NextPC;
        logic       Branch;
        logic       MemW;
        logic       RegW;
        logic       IRWrite;
        logic       AdrSrc;
        logic [1:0] ResultSrc;
        logic [1:0] ALUSrcA;
        logic [1:0] ALUSrcB;
        logic       ALUOp;
    } ctrl_t;

    // States that hold a memory access open and may stall on mem_ready.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_hs_wait_timer.sv
// Saturating wait-state counter with timeout compare.
//   clk, rst   : clock, async active-high reset
//   i_active   : FSM is in a wait-capable state
//   i_ready    : memory completes the access this cycle
//   o_expired  : counter has reached TIMEOUT (never set when TIMEOUT=0)
// The counter clears whenever it is not counting, which covers every state
// change: the FSM only stays put in a wait state while ready is low and the
// timeout has not expired.
module mc_wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_ready,
    output logic o_expired
);
    localparam logic [CNT_W-1:0] LIM     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_count;

    assign o_expired = (TIMEOUT != 0) && (r_cnt == LIM);
    // An expired, not-ready cycle is the last one before FAULT, so it clears.
    assign w_count   = i_active && !i_ready && !o_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (w_count)
            r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        else
            r_cnt <= '0;
    end
endmodule

// File: rtl/mc_ctrl_fsm_hs.sv
// Multicycle main control FSM with memory request/ready handshake,
// wait-state timeout into a sticky FAULT state, and write-back suppression
// for flag-only ALU ops (TST/TEQ/CMP/CMN).
//   clk, reset      : clock, async active-high reset (to FETCH)
//   Op, Funct       : instruction fields (Funct[5]=I, [4:1]=cmd, [0]=S/L)
//   mem_ready       : memory completes the current access this cycle
//   MemReq..ALUOp   : datapath mux selects and enables (combinational)
//   fault           : high while in FAULT
//   state_o         : current state, debug
// TIMEOUT=0 disables the timeout; 2**CNT_W must exceed TIMEOUT.
module mc_ctrl_fsm_hs
    import mc_ctrl_fsm_hs_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       MemReq,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       fault,
    output logic [3:0] state_o
);
    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    logic   w_memreq;
    logic   w_expired;
    logic   w_unused_funct;

    // cmd bits [2:1] do not affect sequencing.
    assign w_unused_funct = ^Funct[2:1];

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (reset),
        .i_active  (is_wait_state(r_state)),
        .i_ready   (mem_ready),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    // Next state. Completion wins over timeout in the same cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_expired) w_next = S_FAULT;
            end
            S_DECODE: begin
                unique case (Op)
                    2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;   // undefined: treated as no-op
                endcase
            end
            S_EXECUTER, S_EXECUTEI: w_next = S_ALUWB;
            S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)      w_next = S_MEMWB;
                else if (w_expired) w_next = S_FAULT;
            end
            S_MEMWR: begin
                if (mem_ready)      w_next = S_FETCH;
                else if (w_expired) w_next = S_FAULT;
            end
            S_MEMWB, S_ALUWB, S_BRANCH: w_next = S_FETCH;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_FETCH;
        endcase
    end

    // Outputs. Enables tied to mem_ready fire only on the completing cycle.
    always_comb begin
        w_ctrl   = '0;
        w_memreq = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_memreq         = 1'b1;
                w_ctrl.ALUSrcA   = SRCA_PC;
                w_ctrl.ALUSrcB   = SRCB_4;
                w_ctrl.ResultSrc = RES_ALURES;
                w_ctrl.IRWrite   = mem_ready;
                w_ctrl.NextPC    = mem_ready;
            end
            S_DECODE: begin
                w_ctrl.ALUSrcA   = SRCA_PC;
                w_ctrl.ALUSrcB   = SRCB_4;
                w_ctrl.ResultSrc = RES_ALURES;
            end
            S_EXECUTER: begin
                w_ctrl.ALUSrcA = SRCA_RN;
                w_ctrl.ALUSrcB = SRCB_RM;
                w_ctrl.ALUOp   = 1'b1;
            end
            S_EXECUTEI: begin
                w_ctrl.ALUSrcA = SRCA_RN;
                w_ctrl.ALUSrcB = SRCB_IMM;
                w_ctrl.ALUOp   = 1'b1;
            end
            S_ALUWB: begin
                w_ctrl.ResultSrc = RES_ALUOUT;
                // cmd 10xx = TST/TEQ/CMP/CMN: flags only, no write-back
                w_ctrl.RegW      = (Funct[4:3] != 2'b10);
            end
            S_MEMADR: begin
                w_ctrl.ALUSrcA = SRCA_RN;
                w_ctrl.ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                w_memreq      = 1'b1;
                w_ctrl.AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.ResultSrc = RES_DATA;
                w_ctrl.RegW      = 1'b1;
            end
            S_MEMWR: begin
                w_memreq      = 1'b1;
                w_ctrl.AdrSrc = 1'b1;
                w_ctrl.MemW   = mem_ready;
            end
            S_BRANCH: begin
                w_ctrl.ALUSrcA   = SRCA_RN;
                w_ctrl.ALUSrcB   = SRCB_IMM;
                w_ctrl.ResultSrc = RES_ALURES;
                w_ctrl.Branch    = 1'b1;
            end
            default: ;   // FAULT and unused encodings: everything off
        endcase
    end

    assign MemReq    = w_memreq;
    assign IRWrite   = w_ctrl.IRWrite;
    assign AdrSrc    = w_ctrl.AdrSrc;
    assign ALUSrcA   = w_ctrl.ALUSrcA;
    assign ALUSrcB   = w_ctrl.ALUSrcB;
    assign ResultSrc = w_ctrl.ResultSrc;
    assign NextPC    = w_ctrl.NextPC;
    assign RegW      = w_ctrl.RegW;
    assign MemW      = w_ctrl.MemW;
    assign Branch    = w_ctrl.Branch;
    assign ALUOp     = w_ctrl.ALUOp;
    assign fault     = (r_state == S_FAULT);
    assign state_o   = r_state;
endmodule

// File: tb/tb_mc_ctrl_fsm_hs.sv
// Scoreboard bench for mc_ctrl_fsm_hs (TIMEOUT=3). The stimulus walks
// instructions at transaction level (fetch, decode, per-class phases, memory
// waits of a chosen length) and pushes the expected per-cycle observation;
// a monitor pops and compares every cycle.
module tb_mc_ctrl_fsm_hs;
    localparam int TO = 3;

    typedef struct packed {
        logic [3:0] st;
        logic       memreq, irw, adrsrc;
        logic [1:0] srca, srcb, res;
        logic       npc, regw, memw, br, aluop, flt;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic       mem_ready = 1'b0;
    logic       MemReq, IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, fault;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] state_o;

    logic [1:0] cur_op = 2'b00;
    logic [5:0] cur_fn = 6'd0;
    obs_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    bit         done = 1'b0;

    mc_ctrl_fsm_hs #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
        .MemReq(MemReq), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp), .fault(fault), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Expected observation for one cycle in phase st (0=FETCH .. 10=FAULT).
    function automatic obs_t model(input int st, input bit r, input logic [5:0] fn);
        obs_t o;
        o = '0;
        o.st = 4'(st);
        case (st)
            0:  begin o.memreq = 1; o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10;
                      o.irw = r; o.npc = r; end
            1:  begin o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10; end
            2:  o.srcb = 2'b01;
            3:  begin o.memreq = 1; o.adrsrc = 1; end
            4:  begin o.res = 2'b01; o.regw = 1; end
            5:  begin o.memreq = 1; o.adrsrc = 1; o.memw = r; end
            6:  o.aluop = 1;
            7:  begin o.srcb = 2'b01; o.aluop = 1; end
            8:  o.regw = (fn[4:3] != 2'b10);
            9:  begin o.srcb = 2'b01; o.res = 2'b10; o.br = 1; end
            10: o.flt = 1;
            default: ;
        endcase
        return o;
    endfunction

    // One clock cycle of stimulus plus its expectation.
    task automatic cyc(input int st, input bit r, input bit rst = 1'b0);
        @(negedge clk);
        reset     = rst;
        mem_ready = r;
        Op        = cur_op;
        Funct     = cur_fn;
        exp_q.push_back(model(st, r, cur_fn));
    endtask

    task automatic rnd_cyc(input int st);
        cyc(st, 1'($urandom_range(0, 1)));
    endtask

    // Memory access in phase st with w not-ready cycles before completion.
    // Waiting more than TO cycles faults; abort resets part-way through.
    task automatic access(input int st, input int w, input bit abort, output bit stop);
        stop = 1'b0;
        if (abort) begin
            for (int k = 0; k < w; k++) cyc(st, 1'b0);
            cyc(0, 1'($urandom_range(0, 1)), 1'b1);
            stop = 1'b1;
            return;
        end
        for (int k = 0; k < w && k <= TO; k++) cyc(st, 1'b0);
        if (w > TO) begin
            rnd_cyc(10);
            rnd_cyc(10);
            cyc(0, 1'($urandom_range(0, 1)), 1'b1);
            stop = 1'b1;
            return;
        end
        cyc(st, 1'b1);
    endtask

    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                             input int wf, input int wm, input bit abort);
        bit stop;
        cur_op = op;
        cur_fn = fn;
        access(0, wf, 1'b0, stop);
        if (stop) return;
        rnd_cyc(1);
        case (op)
            2'b00: begin rnd_cyc(fn[5] ? 7 : 6); rnd_cyc(8); end
            2'b01: begin
                rnd_cyc(2);
                if (fn[0]) begin
                    access(3, wm, abort, stop);
                    if (!stop) rnd_cyc(4);
                end else begin
                    access(5, wm, abort, stop);
                end
            end
            2'b10: rnd_cyc(9);
            default: ;
        endcase
    endtask

    // Monitor: compare the DUT against the queued expectation every cycle.
    initial begin
        obs_t act, expv;
        while (!done) begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                expv = exp_q.pop_front();
                act  = {state_o, MemReq, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                        NextPC, RegW, MemW, Branch, ALUOp, fault};
                vectors++;
                if (act !== expv) begin
                    miscompares++;
                    $display("FAIL cycle_obs t=%0t state got %0d want %0d: got %h want %h",
                             $time, act.st, expv.st, act, expv);
                end
            end
        end
    end

    initial begin
        logic [1:0] op;
        logic [5:0] fn;
        int         wf, wm;
        // Reset state, then release.
        cyc(0, 1'b0, 1'b1);
        cyc(0, 1'b1, 1'b1);
        // Directed cases.
        run_instr(2'b00, 6'b001000, 0, 0, 1'b0);   // ADD reg
        run_instr(2'b00, 6'b110101, 0, 0, 1'b0);   // CMP imm: no write-back
        run_instr(2'b01, 6'b011001, 0, 3, 1'b0);   // LDR, 3 wait states
        run_instr(2'b01, 6'b011000, 0, 1, 1'b0);   // STR, ready on 2nd cycle
        run_instr(2'b01, 6'b011001, TO, TO, 1'b0); // ready exactly at timeout
        run_instr(2'b00, 6'b000000, TO + 1, 0, 1'b0); // fetch timeout -> FAULT
        run_instr(2'b01, 6'b011001, 0, TO + 1, 1'b0); // load timeout
        run_instr(2'b01, 6'b011000, 0, TO + 1, 1'b0); // store timeout
        run_instr(2'b01, 6'b011000, 0, 2, 1'b1);   // reset mid-store-wait
        run_instr(2'b10, 6'b000000, 0, 0, 1'b0);   // branch
        run_instr(2'b11, 6'b111111, 1, 0, 1'b0);   // undefined
        // Random instructions.
        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 3));
            fn = 6'($urandom);
            wf = ($urandom_range(0, 11) == 0) ? TO + 1 : $urandom_range(0, TO);
            wm = ($urandom_range(0, 11) == 0) ? TO + 1 : $urandom_range(0, TO);
            run_instr(op, fn, wf, wm, ($urandom_range(0, 11) == 0) && (wm > 0));
        end
        @(negedge clk);
        #5;
        done = 1'b1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_fsm_hs.md
Name: mc_ctrl_fsm_hs

Overview:
Parametrised successor to the multicycle main control FSM. It adds a memory request/ready handshake, so fetch, load and store can stall for any number of wait states. It adds a wait-state timeout that drops into a sticky FAULT state, and it suppresses register write-back for flag-only ALU ops (TST/TEQ/CMP/CMN). It sits in the multicycle controller next to the condition-check and ALU decoders, and drives the datapath mux and enable signals.

Parameters:
TIMEOUT, 15, maximum wait cycles per memory access before FAULT; 0 disables the timeout.
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; state goes to FETCH
Op  in  2  instruction Op field
Funct  in  6  instruction Funct field (bit5 = I, bits4:1 = cmd, bit0 = S or L)
mem_ready  in  1  memory completes the current access this cycle
MemReq  out  1  memory access request
IRWrite  out  1  instruction register write enable
AdrSrc  out  1  address mux select (0 = PC, 1 = ALU result)
ALUSrcA  out  2  ALU A select (00 = Rn, 01 = PC)
ALUSrcB  out  2  ALU B select (00 = Rm, 01 = ExtImm, 10 = constant 4)
ResultSrc  out  2  result mux select (00 = ALUOut, 01 = Data, 10 = ALUResult)
NextPC  out  1  PC write enable
RegW  out  1  register file write enable
MemW  out  1  memory write enable
Branch  out  1  branch state indicator
ALUOp  out  1  1 = ALU decoder uses Funct, 0 = add
fault  out  1  sticky timeout flag
state_o  out  4  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, FAULT=10.
- Reset: state=FETCH and wait counter=0. All outputs are combinational from state and mem_ready, so during reset the FETCH values appear with IRWrite=NextPC=0 unless mem_ready=1.
- Transitions:
  - FETCH -> DECODE when mem_ready=1; otherwise stay in FETCH.
  - DECODE goes by Op:
    - Op=00: Funct[5]=1 -> EXECUTEI, Funct[5]=0 -> EXECUTER.
    - Op=01 -> MEMADR.
    - Op=10 -> BRANCH.
    - Op=11 -> FETCH (undefined instruction is treated as a no-op).
  - EXECUTER and EXECUTEI -> ALUWB.
  - MEMADR: Funct[0]=1 (load) -> MEMRD, Funct[0]=0 (store) -> MEMWR.
  - MEMRD -> MEMWB when mem_ready=1; otherwise stay.
  - MEMWR -> FETCH when mem_ready=1; otherwise stay.
  - MEMWB, ALUWB and BRANCH -> FETCH.
  - FETCH, MEMRD and MEMWR go to FAULT instead when TIMEOUT≠0, mem_ready=0 and wait counter==TIMEOUT.
  - FAULT stays in FAULT until reset.
- Wait counter:
  - Increments each cycle spent in a wait-capable state (FETCH, MEMRD, MEMWR) with mem_ready=0.
  - Clears on any state change and whenever mem_ready=1.
  - Saturates and never wraps.
- Outputs per state (unlisted outputs = 0):
  - FETCH: MemReq=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0. IRWrite=NextPC=mem_ready, so the PC and IR update only on the completing cycle.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00. RegW=1 unless Funct[4:3]==2'b10 (flag-only ops), in which case RegW=0.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
  - MEMRD: MemReq=1, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: MemReq=1, AdrSrc=1, MemW=mem_ready. The write is single-shot on the completing cycle.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1.
  - FAULT: all enables 0, MemReq=0, fault=1.
- Boundary conditions:
  - mem_ready=1 in the same cycle the counter reaches TIMEOUT: the access completes and no fault occurs.
  - With TIMEOUT=0 the block can wait indefinitely.
  - Reset asserted mid-wait: the access is abandoned, the counter clears, no write is issued, and fault clears.

Decomposition:
- A shared package holds the state localparams, the mux-select constants (SRCA_RN, SRCA_PC, SRCB_RM, SRCB_IMM, SRCB_4, RES_ALUOUT, RES_DATA, RES_ALURES) and the 13-bit control-bundle field order.
- One sub-module is natural: mc_wait_timer, which holds the saturating counter and the timeout compare (inputs: active, ready; output: expired).

Test Plan:
1. ADD register (Op=00, Funct=001000), mem_ready tied 1: FETCH, DECODE, EXECUTER, ALUWB, FETCH in 4 cycles; RegW=1 in ALUWB.
2. CMP immediate (Op=00, Funct=110101): path goes through EXECUTEI with ALUOp=1, then ALUWB with RegW=0.
3. LDR (Op=01, Funct=011001), mem_ready low for 3 cycles in MEMRD: state stays MEMRD for 4 cycles, then MEMWB with RegW=1 and ResultSrc=01, 8 cycles total.
4. STR (Funct[0]=0), mem_ready high in the 2nd MEMWR cycle: MemW pulses exactly 1 cycle, then FETCH.
5. TIMEOUT=3, mem_ready held 0 in FETCH: FAULT entered on cycle 5 with fault=1 and all enables 0; reset returns to FETCH with fault=0.
6. Branch (Op=10): Branch=1, ALUSrcB=01 for one cycle; Op=11 goes DECODE to FETCH with no enables asserted.
